// File: rtl/lamp_pattern_decoder.sv
// lamp_pattern_decoder: receive-side observer for the 8-LED running-lamp bus.
// Identifies which of the four lamp modes is running, locks after a run of
// consistent steps, then tracks phase, counts good steps and flags bad ones.
//
// Strobe semantics: y is sampled only on rising edges where y_valid is high.
// There is no back-pressure; every strobed sample is consumed on that edge.
// With y_valid low, nothing changes except mismatch returning to 0.
module lamp_pattern_decoder #(
    parameter int LOCK_CNT = 4,  // consecutive matching transitions to lock (1..15)
    parameter int ERR_MAX  = 2   // consecutive bad transitions that drop lock (1..15)
) (
    input  logic        clk,
    input  logic        reset,      // asynchronous, active-low
    input  logic        y_valid,
    input  logic [7:0]  y,
    output logic [1:0]  mode,
    output logic        locked,
    output logic        mismatch,
    output logic [2:0]  pos,
    output logic [15:0] step_cnt,
    output logic        dbg_state   // 0 = SEARCH, 1 = LOCKED
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t      state;
    logic        have_prev;
    logic [7:0]  prev_y;
    logic [1:0]  cand;
    logic [3:0]  run;
    logic [3:0]  err_run;

    logic [3:0]  match;
    logic        match_any;
    logic [1:0]  match_idx;
    logic [1:0]  cand_nxt;
    logic [3:0]  run_nxt;
    logic [3:0]  lock_pos;
    logic [3:0]  trk_pos;

    // True when exactly one bit of p is set.
    function automatic logic is_onehot(input logic [7:0] p);
        return (p != 8'h00) && ((p & (p - 8'h01)) == 8'h00);
    endfunction

    // Phase of pattern p within mode m: {recognised, index}.
    function automatic logic [3:0] pos_of(input logic [1:0] m, input logic [7:0] p);
        logic [3:0] r;
        r = 4'b0000;
        case (m)
            2'd0, 2'd1: begin
                if (is_onehot(p)) begin
                    for (int i = 0; i < 8; i++) begin
                        if (p[i]) r = {1'b1, 3'(i)};
                    end
                end
            end
            2'd2: begin
                case (p)
                    8'h81:   r = 4'b1000;
                    8'h42:   r = 4'b1001;
                    8'h24:   r = 4'b1010;
                    8'h18:   r = 4'b1011;
                    default: r = 4'b0000;
                endcase
            end
            default: begin
                case (p)
                    8'hFF:   r = 4'b1000;
                    8'h00:   r = 4'b1001;
                    default: r = 4'b0000;
                endcase
            end
        endcase
        return r;
    endfunction

    // Classify the transition prev_y -> y against each mode's successor rule.
    always_comb begin
        match = 4'b0000;
        if (is_onehot(prev_y)) begin
            if (y == {prev_y[6:0], prev_y[7]}) match[0] = 1'b1;
            if (y == {prev_y[0], prev_y[7:1]}) match[1] = 1'b1;
        end
        case (prev_y)
            8'h81:   if (y == 8'h42) match[2] = 1'b1;
            8'h42:   if (y == 8'h24) match[2] = 1'b1;
            8'h24:   if (y == 8'h18) match[2] = 1'b1;
            8'h18:   if (y == 8'h81) match[2] = 1'b1;
            8'hFF:   if (y == 8'h00) match[3] = 1'b1;
            8'h00:   if (y == 8'hFF) match[3] = 1'b1;
            default: ;
        endcase
    end

    // Encode the (at most one-hot) match vector; pattern sets are disjoint.
    always_comb begin
        match_any = |match;
        match_idx = 2'd0;
        if (match[1]) match_idx = 2'd1;
        if (match[2]) match_idx = 2'd2;
        if (match[3]) match_idx = 2'd3;
    end

    // Candidate tracking while searching: extend the run or restart it.
    always_comb begin
        cand_nxt = cand;
        run_nxt  = 4'd0;
        if (match_any) begin
            if ((match_idx == cand) && (run != 4'd0)) begin
                run_nxt = run + 4'd1;
            end else begin
                cand_nxt = match_idx;
                run_nxt  = 4'd1;
            end
        end
        lock_pos = pos_of(cand_nxt, y);
        trk_pos  = pos_of(mode, y);
    end

    assign locked    = (state == LOCKED);
    assign dbg_state = state;

    // Search/lock state machine with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SEARCH;
            have_prev <= 1'b0;
            prev_y    <= 8'h00;
            cand      <= 2'd0;
            run       <= 4'd0;
            err_run   <= 4'd0;
            mode      <= 2'd0;
            mismatch  <= 1'b0;
            pos       <= 3'd0;
            step_cnt  <= 16'd0;
        end else begin
            mismatch <= 1'b0;
            if (y_valid) begin
                prev_y    <= y;
                have_prev <= 1'b1;
                if (have_prev) begin
                    case (state)
                        SEARCH: begin
                            cand <= cand_nxt;
                            run  <= run_nxt;
                            if (match_any && (run_nxt == 4'(LOCK_CNT))) begin
                                state    <= LOCKED;
                                mode     <= cand_nxt;
                                step_cnt <= 16'd0;
                                err_run  <= 4'd0;
                                if (lock_pos[3]) pos <= lock_pos[2:0];
                            end
                        end
                        default: begin
                            if (trk_pos[3]) pos <= trk_pos[2:0];
                            if (match_any && (match_idx == mode)) begin
                                err_run <= 4'd0;
                                if (step_cnt != 16'hFFFF) step_cnt <= step_cnt + 16'd1;
                            end else begin
                                mismatch <= 1'b1;
                                if ((err_run + 4'd1) == 4'(ERR_MAX)) begin
                                    state <= SEARCH;
                                    run   <= 4'd0;
                                end else begin
                                    err_run <= err_run + 4'd1;
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule
